// File: rtl/clk_div_gen.sv
// Reconfigurable clock divider with a valid/ready configuration port.
// A new divide ratio, high time and duty mode are held in a shadow copy and
// only become active at a period boundary, so div_clk_o never emits a runt.
// tick_o is a one-cycle enable in the clk_i domain marking each period start.
module clk_div_gen #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DEFAULT_DIV = 1
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             div_en_i,
   input  logic             cfg_vld_i,
   output logic             cfg_rdy_o,
   input  logic [WIDTH-1:0] div_data_i,
   input  logic [WIDTH-1:0] high_data_i,
   input  logic             duty_mode_i,
   output logic             div_clk_o,
   output logic             tick_o
);

   localparam logic [WIDTH-1:0] NOne = WIDTH'(1);
   localparam logic [WIDTH:0]   XOne = (WIDTH + 1)'(1);
   localparam logic [WIDTH-1:0] DefN = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DefH = WIDTH'(DEFAULT_DIV >> 1);

   // Effective high time in clk_i cycles for a given configuration.
   // Computed one bit wider so (N+1)/2 cannot overflow at N = 2^WIDTH-1.
   function automatic logic [WIDTH:0] calc_h_eff(input logic [WIDTH-1:0] n,
                                                 input logic [WIDTH-1:0] h,
                                                 input logic             mode);
      logic [WIDTH:0] n_x;
      logic [WIDTH:0] h_x;
      logic [WIDTH:0] r;
      n_x = {1'b0, n};
      h_x = {1'b0, h};
      if (n <= NOne) begin
         r = XOne;
      end else if (!mode) begin
         r = n[0] ? ((n_x + XOne) >> 1) : (n_x >> 1);
      end else if (h == '0) begin
         r = XOne;
      end else if (h_x >= n_x) begin
         r = n_x - XOne;
      end else begin
         r = h_x;
      end
      return r;
   endfunction

   // Counter and output state
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             p_clk_q, p_clk_d;
   logic             n_clk_q, n_clk_d;
   logic             tick_q, tick_d;
   logic             run_q, run_d;

   // Configuration state: shadow (staged) and active copies
   logic             pending_q, pending_d;
   logic             cfg_rdy_q, cfg_rdy_d;
   logic [WIDTH-1:0] shd_n_q, shd_n_d;
   logic [WIDTH-1:0] shd_h_q, shd_h_d;
   logic             shd_mode_q, shd_mode_d;
   logic [WIDTH-1:0] act_n_q, act_n_d;
   logic [WIDTH-1:0] act_h_q, act_h_d;
   logic             act_mode_q, act_mode_d;

   // Decoded helpers
   logic             act_bypass;
   logic             accept;
   logic             apply;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] eff_n;
   logic [WIDTH-1:0] eff_h;
   logic             eff_mode;
   logic [WIDTH:0]   h_eff;

   // Next-state for counter, phase register, tick and configuration handshake.
   always_comb begin
      act_bypass = (act_n_q <= NOne);
      accept     = cfg_vld_i & cfg_rdy_q;

      // Bypass holds the count at 0 so every edge looks like a wrap.
      if (!run_q || act_bypass) begin
         cnt_next = '0;
      end else if (cnt_q == (act_n_q - NOne)) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_q + NOne;
      end

      // A stopped or bypassed divider has no period to protect, so apply at once.
      apply = pending_q & ((cnt_next == '0) | !div_en_i | act_bypass);

      // The apply edge itself already runs on the new configuration.
      eff_n    = apply ? shd_n_q    : act_n_q;
      eff_h    = apply ? shd_h_q    : act_h_q;
      eff_mode = apply ? shd_mode_q : act_mode_q;
      h_eff    = calc_h_eff(eff_n, eff_h, eff_mode);

      cnt_d   = div_en_i ? cnt_next : '0;
      p_clk_d = div_en_i & ({1'b0, cnt_next} < h_eff);
      tick_d  = div_en_i & (cnt_next == '0);
      run_d   = div_en_i;

      shd_n_d    = accept ? div_data_i  : shd_n_q;
      shd_h_d    = accept ? high_data_i : shd_h_q;
      shd_mode_d = accept ? duty_mode_i : shd_mode_q;

      act_n_d    = apply ? shd_n_q    : act_n_q;
      act_h_d    = apply ? shd_h_q    : act_h_q;
      act_mode_d = apply ? shd_mode_q : act_mode_q;

      pending_d = pending_q;
      if (accept) begin
         pending_d = 1'b1;
      end else if (apply) begin
         pending_d = 1'b0;
      end

      // Ready reopens one edge after the apply edge has cleared pending.
      cfg_rdy_d = cfg_rdy_q;
      if (accept) begin
         cfg_rdy_d = 1'b0;
      end else if (!pending_q) begin
         cfg_rdy_d = 1'b1;
      end

      n_clk_d = p_clk_q;
   end

   // Rising-edge state registers.
   always_ff @(posedge clk_i or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         p_clk_q    <= 1'b0;
         tick_q     <= 1'b0;
         run_q      <= 1'b0;
         pending_q  <= 1'b0;
         cfg_rdy_q  <= 1'b1;
         shd_n_q    <= DefN;
         shd_h_q    <= DefH;
         shd_mode_q <= 1'b0;
         act_n_q    <= DefN;
         act_h_q    <= DefH;
         act_mode_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         p_clk_q    <= p_clk_d;
         tick_q     <= tick_d;
         run_q      <= run_d;
         pending_q  <= pending_d;
         cfg_rdy_q  <= cfg_rdy_d;
         shd_n_q    <= shd_n_d;
         shd_h_q    <= shd_h_d;
         shd_mode_q <= shd_mode_d;
         act_n_q    <= act_n_d;
         act_h_q    <= act_h_d;
         act_mode_q <= act_mode_d;
      end
   end

   // Half-cycle delayed phase, used to trim odd ratios to an exact N/2 high time.
   always_ff @(negedge clk_i or posedge rst) begin
      if (rst) begin
         n_clk_q <= 1'b0;
      end else begin
         n_clk_q <= n_clk_d;
      end
   end

   // Output select: bypass mux, odd-ratio trim, or plain phase register.
   always_comb begin
      div_clk_o = p_clk_q;
      if (act_bypass) begin
         div_clk_o = clk_i & div_en_i;
      end else if (!act_mode_q && act_n_q[0]) begin
         div_clk_o = p_clk_q & n_clk_q;
      end
      tick_o    = tick_q;
      cfg_rdy_o = cfg_rdy_q;
   end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus randomized
// configurations, each measured at half-cycle resolution against the expected
// period, high time and tick placement derived from the divider's rules.
module tb_clk_div_gen;

   localparam int unsigned WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             rst;
   logic             div_en_i;
   logic             cfg_vld_i;
   logic             cfg_rdy_o;
   logic [WIDTH-1:0] div_data_i;
   logic [WIDTH-1:0] high_data_i;
   logic             duty_mode_i;
   logic             div_clk_o;
   logic             tick_o;

   int checks = 0;
   int errors = 0;

   clk_div_gen #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(1)
   ) u_dut (
      .clk_i      (clk_i),
      .rst        (rst),
      .div_en_i   (div_en_i),
      .cfg_vld_i  (cfg_vld_i),
      .cfg_rdy_o  (cfg_rdy_o),
      .div_data_i (div_data_i),
      .high_data_i(high_data_i),
      .duty_mode_i(duty_mode_i),
      .div_clk_o  (div_clk_o),
      .tick_o     (tick_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Expected high time in half cycles: auto mode gives exactly N/2 cycles,
   // programmed mode gives H limited to the range 1..N-1.
   function automatic int model_high_half(input int n, input int h, input bit mode);
      int hh;
      if (!mode) return n;
      hh = h;
      if (hh < 1) hh = 1;
      if (hh > n - 1) hh = n - 1;
      return 2 * hh;
   endfunction

   task automatic step_pos();
      @(posedge clk_i);
      #1;
   endtask

   task automatic step_neg();
      @(negedge clk_i);
      #1;
   endtask

   // Offer a configuration once ready is seen and confirm it is taken.
   task automatic cfg_write(input int n, input int h, input bit mode);
      int k;
      k = 0;
      @(negedge clk_i);
      while (!cfg_rdy_o && k < 400) begin
         @(negedge clk_i);
         k++;
      end
      if (k >= 400) chk("cfg_rdy_timeout", 0, 1);
      cfg_vld_i   = 1'b1;
      div_data_i  = WIDTH'(n);
      high_data_i = WIDTH'(h);
      duty_mode_i = mode;
      step_pos();
      cfg_vld_i = 1'b0;
      chk("rdy_low_after_accept", cfg_rdy_o, 0);
   endtask

   task automatic wait_applied();
      int k;
      k = 0;
      while (!cfg_rdy_o && k < 600) begin
         step_pos();
         k++;
      end
      if (k >= 600) chk("apply_timeout", 0, 1);
   endtask

   task automatic sync_tick();
      int k;
      k = 0;
      step_pos();
      while (!tick_o && k < 600) begin
         step_pos();
         k++;
      end
      if (k >= 600) chk("tick_timeout", 0, 1);
   endtask

   // Measure one full period starting at a tick.
   task automatic measure(input string tag, input int n, input int want_hi, input bit odd_auto);
      int hi;
      int ticks;
      logic first_div;
      hi = 0;
      ticks = 0;
      first_div = div_clk_o;
      for (int i = 0; i < n; i++) begin
         if (tick_o) ticks++;
         if (div_clk_o) hi++;
         step_neg();
         if (div_clk_o) hi++;
         step_pos();
      end
      chk({tag, "_high_half"}, hi, want_hi);
      chk({tag, "_ticks_per_period"}, ticks, 1);
      chk({tag, "_tick_at_period_end"}, tick_o, 1);
      if (!odd_auto) chk({tag, "_rise_with_tick"}, first_div, 1);
   endtask

   task automatic check_bypass(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step_pos();
         chk({tag, "_tick"}, tick_o, 1);
         chk({tag, "_div_hi"}, div_clk_o, 1);
         step_neg();
         chk({tag, "_div_lo"}, div_clk_o, 0);
      end
   endtask

   task automatic run_cfg(input string tag, input int n, input int h, input bit mode);
      cfg_write(n, h, mode);
      wait_applied();
      if (n <= 1) begin
         check_bypass(tag, 3);
      end else begin
         sync_tick();
         measure(tag, n, model_high_half(n, h, mode), !mode && (n % 2 == 1));
      end
   endtask

   initial begin
      int cyc;
      int rn;
      int rh;
      bit rm;

      rst         = 1'b1;
      div_en_i    = 1'b1;
      cfg_vld_i   = 1'b0;
      div_data_i  = '0;
      high_data_i = '0;
      duty_mode_i = 1'b0;

      // Reset state: bypass with enable set, so output follows clk_i.
      #2;
      chk("rst_tick", tick_o, 0);
      chk("rst_rdy", cfg_rdy_o, 1);
      chk("rst_div_low_phase", div_clk_o, 0);
      step_pos();
      chk("rst_div_high_phase", div_clk_o, 1);
      chk("rst_tick_held", tick_o, 0);
      @(negedge clk_i);
      rst = 1'b0;
      check_bypass("bypass_default", 4);
      chk("bypass_rdy", cfg_rdy_o, 1);

      // Directed ratios and duty modes.
      run_cfg("n4", 4, 0, 1'b0);
      sync_tick();
      measure("n4_again", 4, 4, 1'b0);
      run_cfg("n5", 5, 0, 1'b0);
      run_cfg("n10_h3", 10, 3, 1'b1);
      run_cfg("n10_h0", 10, 0, 1'b1);
      run_cfg("n10_h12", 10, 12, 1'b1);
      run_cfg("n255", 255, 0, 1'b0);
      run_cfg("n2", 2, 0, 1'b0);

      // Mid-period reconfiguration: old period completes, second request dropped.
      run_cfg("n6", 6, 0, 1'b0);
      sync_tick();
      step_pos();
      step_pos();
      cfg_vld_i   = 1'b1;
      div_data_i  = WIDTH'(3);
      high_data_i = '0;
      duty_mode_i = 1'b0;
      step_pos();
      cfg_vld_i = 1'b0;
      chk("mid_rdy_low", cfg_rdy_o, 0);
      cfg_vld_i  = 1'b1;
      div_data_i = WIDTH'(9);
      step_pos();
      cfg_vld_i = 1'b0;
      chk("mid_rdy_still_low", cfg_rdy_o, 0);
      cyc = 4;
      while (!tick_o && cyc < 40) begin
         step_pos();
         cyc++;
      end
      chk("mid_old_period", cyc, 6);
      chk("mid_rdy_at_apply", cfg_rdy_o, 0);
      step_pos();
      chk("mid_rdy_after_apply", cfg_rdy_o, 1);
      sync_tick();
      measure("mid_new_a", 3, 3, 1'b1);
      measure("mid_new_b", 3, 3, 1'b1);

      // Disable at cnt=1 of N=8, then re-enable.
      run_cfg("n8", 8, 0, 1'b0);
      sync_tick();
      step_pos();
      chk("dis_pre_div", div_clk_o, 1);
      @(negedge clk_i);
      div_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step_pos();
         chk("dis_div", div_clk_o, 0);
         chk("dis_tick", tick_o, 0);
      end
      @(negedge clk_i);
      div_en_i = 1'b1;
      step_pos();
      chk("reen_tick", tick_o, 1);
      chk("reen_div", div_clk_o, 1);
      step_pos();
      chk("reen_tick_drop", tick_o, 0);
      chk("reen_div_hold", div_clk_o, 1);

      // Randomized configurations, including bypass ratios.
      for (int it = 0; it < 14; it++) begin
         rn = $urandom_range(0, 20);
         rh = $urandom_range(0, 24);
         rm = 1'($urandom_range(0, 1));
         run_cfg($sformatf("rnd%0d", it), rn, rh, rm);
      end

      // Reset mid-period with a configuration pending: it must be discarded.
      run_cfg("n8b", 8, 0, 1'b0);
      sync_tick();
      step_pos();
      cfg_write(3, 0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_tick", tick_o, 0);
      chk("arst_rdy", cfg_rdy_o, 1);
      chk("arst_div_follows_clk", div_clk_o, clk_i);
      @(negedge clk_i);
      rst = 1'b0;
      check_bypass("post_rst", 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
